// File: rtl/klotski_sequencer_pkg.sv
// Shared types and the fixed solve plan for the klotski sequencer.
// Plan entry n places tile n+1 at row n/4, col n%4.
package klotski_sequencer_pkg;

  typedef logic [3:0][3:0][3:0] board_t;
  typedef logic [3:0][3:0]      mask_t;
  typedef logic [1:0]           pos_t;

  typedef struct packed {
    logic [3:0] number;
    pos_t       row;
    pos_t       col;
  } plan_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int unsigned PLAN_LEN = 15;

  localparam plan_entry_t PLAN [PLAN_LEN] = '{
    '{4'h1, 2'd0, 2'd0}, '{4'h2, 2'd0, 2'd1}, '{4'h3, 2'd0, 2'd2}, '{4'h4, 2'd0, 2'd3},
    '{4'h5, 2'd1, 2'd0}, '{4'h6, 2'd1, 2'd1}, '{4'h7, 2'd1, 2'd2}, '{4'h8, 2'd1, 2'd3},
    '{4'h9, 2'd2, 2'd0}, '{4'hA, 2'd2, 2'd1}, '{4'hB, 2'd2, 2'd2}, '{4'hC, 2'd2, 2'd3},
    '{4'hD, 2'd3, 2'd0}, '{4'hE, 2'd3, 2'd1}, '{4'hF, 2'd3, 2'd2}
  };

  // Steps beyond the plan read as an all-zero entry instead of indexing out of range.
  function automatic plan_entry_t plan_at(input logic [3:0] s);
    plan_entry_t e;
    e = '0;
    if (s < 4'(PLAN_LEN)) e = PLAN[s];
    return e;
  endfunction

endpackage

// File: rtl/klotski_sequencer_if.sv
// MoveNum operand/result bundle used at the parent level to wire the
// sequencer to MoveNum.
interface klotski_sequencer_if;
  import klotski_sequencer_pkg::*;

  logic             start;
  board_t           klotski;
  mask_t            mask;
  logic [1:0][1:0]  target;
  logic [3:0]       number;
  board_t           res_klotski;
  mask_t            res_mask;
  logic             finished;

  modport master (
    output start, klotski, mask, target, number,
    input  res_klotski, res_mask, finished
  );

  modport slave (
    input  start, klotski, mask, target, number,
    output res_klotski, res_mask, finished
  );

endinterface

// File: rtl/klotski_sequencer.sv
// Walks the fixed solve plan, asking MoveNum to place each tile that is not
// already in position, and reports done or error after checking each placement.
module klotski_sequencer
  import klotski_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STEPS    = 15,
  parameter int unsigned STEP_TIMEOUT = 4096
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  board_t          i_klotski,
  output logic            o_mv_start,
  output board_t          o_mv_klotski,
  output mask_t           o_mv_mask,
  output logic [1:0][1:0] o_mv_target,
  output logic [3:0]      o_mv_number,
  input  board_t          i_mv_klotski,
  input  mask_t           i_mv_mask,
  input  logic            i_mv_finished,
  output board_t          o_klotski,
  output logic [3:0]      o_step,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_error
);

  localparam int unsigned TW = (STEP_TIMEOUT > 2) ? $clog2(STEP_TIMEOUT) : 1;

  state_t          state;
  board_t          board;
  mask_t           mask;
  logic [3:0]      step;
  logic [TW-1:0]   tcnt;
  logic [TW-1:0]   tcnt_next;
  logic            mv_start;
  logic [1:0][1:0] mv_target;
  logic [3:0]      mv_number;
  logic            done;
  logic            error;
  plan_entry_t     cur;

  always_comb begin
    cur       = plan_at(step);
    tcnt_next = tcnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      board     <= '0;
      mask      <= '0;
      step      <= '0;
      tcnt      <= '0;
      mv_start  <= 1'b0;
      mv_target <= '0;
      mv_number <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mv_start <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) state <= S_LOAD;
        end
        S_LOAD: begin
          board <= i_klotski;
          mask  <= '0;
          step  <= '0;
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (board[cur.row][cur.col] == cur.number) begin
            state <= S_COMMIT;
          end else begin
            // Operands are registered here so they stay frozen through WAIT.
            mv_start  <= 1'b1;
            mv_target <= {cur.row, cur.col};
            mv_number <= cur.number;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          tcnt <= tcnt_next;
          // Comparing the incremented count lands ERROR exactly STEP_TIMEOUT
          // cycles after the start pulse; a finish in that cycle still wins.
          if (i_mv_finished) begin
            board <= i_mv_klotski;
            mask  <= i_mv_mask;
            state <= S_COMMIT;
          end else if (tcnt_next == TW'(STEP_TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= S_ERROR;
          end
        end
        S_COMMIT: begin
          if (board[cur.row][cur.col] != cur.number) begin
            error <= 1'b1;
            state <= S_ERROR;
          end else begin
            mask[cur.row][cur.col] <= 1'b1;
            if (step == 4'(NUM_STEPS - 1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              step  <= step + 1'b1;
              state <= S_CHECK;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_mv_start   = mv_start;
  assign o_mv_klotski = board;
  assign o_mv_mask    = mask;
  assign o_mv_target  = mv_target;
  assign o_mv_number  = mv_number;
  assign o_klotski    = board;
  assign o_step       = step;
  assign o_busy       = (state != S_IDLE);
  assign o_done       = done;
  assign o_error      = error;

endmodule

// File: tb/tb_klotski_sequencer.sv
// Scoreboard bench for klotski_sequencer: stimulus queues expected end-of-run
// and snapshot results, a negedge monitor pops and compares them.
module tb_klotski_sequencer;
  import klotski_sequencer_pkg::*;

  localparam int TMO = 16;
  localparam logic [63:0] SOLVED  = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] SWAPPED = 64'hF0ED_CBA9_8765_4321;
  localparam logic [63:0] WRONG   = 64'h03ED_CBA9_8765_4321;
  localparam logic [63:0] JUNK    = 64'h1111_2222_3333_4444;

  localparam int K_DONE  = 0;
  localparam int K_ERROR = 1;
  localparam int K_PROBE = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [63:0] board;
    logic [15:0] mask;
    logic [3:0]  step;
    bit          busy;
    int          starts;
    int          lat;
    int          plat;
    int          pstep;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  board_t     board_in;
  board_t     board_out;
  logic [3:0] step;
  logic       busy;
  logic       done;
  logic       error;

  klotski_sequencer_if mv_bus();

  klotski_sequencer #(
    .NUM_STEPS   (15),
    .STEP_TIMEOUT(TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_klotski    (board_in),
    .o_mv_start   (mv_bus.start),
    .o_mv_klotski (mv_bus.klotski),
    .o_mv_mask    (mv_bus.mask),
    .o_mv_target  (mv_bus.target),
    .o_mv_number  (mv_bus.number),
    .i_mv_klotski (mv_bus.res_klotski),
    .i_mv_mask    (mv_bus.res_mask),
    .i_mv_finished(mv_bus.finished),
    .o_klotski    (board_out),
    .o_step       (step),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   probe_req = 0;
  int   probe_ack = 0;
  int   inj_req = 0;
  int   inj_ack = 0;
  int   mdl_mode = 0;
  int   mdl_delay = 0;
  logic [63:0] mdl_board = '0;

  // MoveNum model: responds to a start pulse after mdl_delay cycles, or
  // injects an unsolicited finished pulse when asked.
  initial begin
    mv_bus.finished    = 1'b0;
    mv_bus.res_klotski = '0;
    mv_bus.res_mask    = '0;
    forever begin
      @(negedge clk);
      if (inj_req != inj_ack) begin
        inj_ack            = inj_req;
        mv_bus.res_klotski = mdl_board;
        mv_bus.res_mask    = '1;
        mv_bus.finished    = 1'b1;
        @(negedge clk);
        mv_bus.finished    = 1'b0;
      end else if (mdl_mode == 1 && mv_bus.start) begin
        mv_bus.res_mask = mv_bus.mask;
        repeat (mdl_delay) @(posedge clk);
        #1;
        mv_bus.res_klotski = mdl_board;
        mv_bus.finished    = 1'b1;
        @(posedge clk);
        #1;
        mv_bus.finished    = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  int   run_cyc = 0;
  int   run_pulses = 0;
  int   pulse_cyc = 0;
  int   pulse_step = 0;
  bit   chk_idle = 0;
  int   wd = 0;
  exp_t e;

  always @(negedge clk) begin
    if (start && !busy) begin
      run_cyc    = cyc;
      run_pulses = 0;
    end
    if (mv_bus.start) begin
      run_pulses++;
      pulse_cyc  = cyc;
      pulse_step = int'(step);
    end
    if (chk_idle) begin
      chk_idle = 0;
      chk("busy after end", 64'(busy), 64'(0));
      chk("end pulse width", 64'({done, error}), 64'(0));
    end else if (done || error || probe_req != probe_ack) begin
      if (!(done || error)) probe_ack++;
      if (sb.size() == 0) begin
        chk("unexpected end event", 64'({done, error}), 64'(0));
      end else begin
        e  = sb.pop_front();
        wd = 0;
        chk({e.name, " done"},  64'(done),  64'(e.kind == K_DONE));
        chk({e.name, " error"}, 64'(error), 64'(e.kind == K_ERROR));
        chk({e.name, " busy"},  64'(busy),  64'(e.busy));
        chk({e.name, " board"}, board_out,  e.board);
        chk({e.name, " mask"},  64'(mv_bus.mask), 64'(e.mask));
        chk({e.name, " step"},  64'(step),  64'(e.step));
        if (e.starts >= 0) chk({e.name, " start pulses"}, 64'(run_pulses), 64'(e.starts));
        if (e.lat >= 0)    chk({e.name, " latency"}, 64'(cyc - run_cyc), 64'(e.lat));
        if (e.plat >= 0)   chk({e.name, " cycles after pulse"}, 64'(cyc - pulse_cyc), 64'(e.plat));
        if (e.pstep >= 0)  chk({e.name, " pulse step"}, 64'(pulse_step), 64'(e.pstep));
        if (e.kind != K_PROBE) chk_idle = 1;
      end
    end else if (sb.size() != 0) begin
      wd++;
      if (wd > 300) begin
        e  = sb.pop_front();
        wd = 0;
        chk({e.name, " event timeout"}, 64'(0), 64'(1));
      end
    end
  end

  function automatic exp_t mk(input string nm, input int kind, input logic [63:0] b,
                              input logic [15:0] m, input logic [3:0] s, input bit bz,
                              input int starts, input int lat, input int plat, input int pstep);
    exp_t x;
    x.name = nm; x.kind = kind; x.board = b; x.mask = m; x.step = s; x.busy = bz;
    x.starts = starts; x.lat = lat; x.plat = plat; x.pstep = pstep;
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [63:0] b);
    board_in = b;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() != 0) @(negedge clk);
    tick(2);
  endtask

  initial begin
    #400000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    board_in = '0;
    tick(3);
    rst_n = 1'b1;
    sb.push_back(mk("reset", K_PROBE, '0, '0, 4'd0, 0, -1, -1, -1, -1));
    probe_req++;
    drain();

    // Already solved: all steps skip.
    sb.push_back(mk("solved", K_DONE, SOLVED, 16'h7FFF, 4'd14, 1, 0, 32, -1, -1));
    go(SOLVED);
    drain();

    // Stray finished pulse while idle must not touch the retained board.
    mdl_board = JUNK;
    inj_req++;
    tick(3);
    sb.push_back(mk("idle finished", K_PROBE, SOLVED, 16'h7FFF, 4'd14, 0, -1, -1, -1, -1));
    probe_req++;
    drain();

    // 15 and blank swapped: one MoveNum call at step 14.
    mdl_mode = 1; mdl_delay = 5; mdl_board = SOLVED;
    sb.push_back(mk("one move", K_DONE, SOLVED, 16'h7FFF, 4'd14, 1, 1, 38, -1, 14));
    go(SWAPPED);
    drain();

    // MoveNum returns the wrong tile at the target.
    mdl_mode = 1; mdl_delay = 2; mdl_board = WRONG;
    sb.push_back(mk("wrong tile", K_ERROR, WRONG, 16'h3FFF, 4'd14, 1, 1, 35, -1, 14));
    go(SWAPPED);
    drain();

    // MoveNum never finishes.
    mdl_mode = 0;
    sb.push_back(mk("timeout", K_ERROR, SWAPPED, 16'h3FFF, 4'd14, 1, 1, 31 + TMO, TMO, 14));
    go(SWAPPED);
    drain();

    // Reset mid-WAIT followed by a late finished pulse.
    go(SWAPPED);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mv_bus.start) break;
    end
    tick(1);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    mdl_board = SOLVED;
    inj_req++;
    tick(2);
    sb.push_back(mk("reset in wait", K_PROBE, '0, '0, 4'd0, 0, -1, -1, -1, -1));
    probe_req++;
    drain();

    // Second start while busy is ignored.
    sb.push_back(mk("mid run", K_PROBE, SOLVED, 16'h0003, 4'd2, 1, -1, -1, -1, -1));
    sb.push_back(mk("restart ignored", K_DONE, SOLVED, 16'h7FFF, 4'd14, 1, 0, 32, -1, -1));
    go(SOLVED);
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    probe_req++;
    drain();

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/klotski_sequencer.md
KLOTSKI_SEQUENCER -- requirements
Module: klotski_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STEPS, default 15: number of entries in the solve plan.
REQ-002 The block SHALL have parameter STEP_TIMEOUT, default 4096: maximum number of cycles the block waits for each move_num step.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port i_start, input, 1 bit: one-cycle pulse that starts a solve; it is accepted only in IDLE.
REQ-006 The block SHALL have port i_klotski, input, [3:0][3:0][3:0]: the scrambled board, indexed [row][col], 4-bit tile value, 0 = blank.
REQ-007 The block SHALL have port o_mv_start, output, 1 bit: one-cycle start pulse to MoveNum.
REQ-008 The block SHALL have ports o_mv_klotski [3:0][3:0][3:0], o_mv_mask [3:0][3:0], o_mv_target [1:0][1:0] ({row,col}) and o_mv_number [3:0], all outputs, as the operands sent to MoveNum.
REQ-009 The block SHALL have ports i_mv_klotski [3:0][3:0][3:0], i_mv_mask [3:0][3:0] and i_mv_finished (1 bit), all inputs, as the results returned by MoveNum.
REQ-010 The block SHALL have port o_klotski, output, [3:0][3:0][3:0]: the working board.
REQ-011 The block SHALL have port o_step, output, [3:0]: index of the current plan step.
REQ-012 The block SHALL have ports o_busy, o_done and o_error, outputs, 1 bit each: solve status.

Function
REQ-013 The state machine SHALL have the states IDLE, LOAD, CHECK, ISSUE, WAIT, COMMIT, DONE and ERROR.
REQ-014 In IDLE, when i_start=1, the block SHALL go to LOAD next cycle; i_start in any other state SHALL be ignored.
REQ-015 In LOAD, the block SHALL latch i_klotski into the working board, clear the working mask to 0 and set step=0; next state is CHECK.
REQ-016 In CHECK, the block SHALL read plan[step] = {number, row, col}.
- If board[row][col]==number: go to COMMIT (skip path, no o_mv_start pulse).
- Otherwise: go to ISSUE.
REQ-017 In ISSUE, the block SHALL drive o_mv_start=1 for exactly one cycle, clear the timeout counter and go to WAIT.
- o_mv_klotski, o_mv_mask, o_mv_target and o_mv_number SHALL hold stable from ISSUE until the WAIT state exits.
REQ-018 In WAIT, when i_mv_finished=1, the block SHALL latch i_mv_klotski and i_mv_mask into the working registers and go to COMMIT.
- The timeout counter increments every WAIT cycle.
- When the counter reaches STEP_TIMEOUT-1 without i_mv_finished, the block SHALL go to ERROR.
- If i_mv_finished=1 in that same cycle, finished SHALL take priority over the timeout.
REQ-019 In COMMIT, the block SHALL set mask[row][col]=1 for plan[step].
- If step==NUM_STEPS-1: go to DONE.
- Otherwise: increment step and go to CHECK.
REQ-020 In COMMIT, if the committed board[row][col] is not equal to number, the block SHALL go to ERROR.
REQ-021 DONE and ERROR SHALL each hold for exactly one cycle (o_done=1 or o_error=1), then return to IDLE; o_klotski SHALL retain the final board.
REQ-022 o_busy SHALL be 1 in every state except IDLE.
REQ-023 o_step SHALL reflect the step register at all times.
REQ-024 An i_mv_finished pulse arriving outside WAIT SHALL be ignored.
REQ-025 Latency for the all-skip (already solved) case SHALL be 2+2*NUM_STEPS cycles from the i_start cycle to the o_done cycle.

Reset
REQ-026 When i_rst_n=0 at a rising edge, the block SHALL return to IDLE.
REQ-027 On reset, step, the mask, the board, the timeout counter, o_mv_start, o_done and o_error SHALL be cleared to 0; reset SHALL take priority over all other events, including mid-WAIT.
REQ-028 After a reset during WAIT, a late i_mv_finished SHALL be ignored.

Structure
REQ-029 The types board_t ([3:0][3:0][3:0]), mask_t, pos_t, the plan_entry_t struct {number, row, col} and the constant PLAN array SHALL live in the shared klotski package.
- PLAN entry n SHALL be {n+1, n/4, n%4} for n = 0..14.
REQ-030 No sub-module SHALL be instantiated; MoveNum SHALL connect externally at the parent level.

Verification
REQ-031 Solved board (row-major 1..15, then 0), i_start -> zero o_mv_start pulses, o_done at cycle 32 after i_start, all 15 mask bits set.
REQ-032 Solved board except 15 and 0 swapped, with a MoveNum model that returns the solved board after 5 cycles -> exactly one o_mv_start at step 14, o_done, o_klotski solved.
REQ-033 With a model that never asserts finished -> o_error exactly STEP_TIMEOUT cycles after the o_mv_start pulse, then IDLE.
REQ-034 With a model that returns a board with the wrong tile at the target -> o_error in the COMMIT cycle.
REQ-035 With i_rst_n=0 during WAIT and a finished pulse one cycle later -> IDLE, o_busy=0, no latch of the late result.
REQ-036 A second i_start while o_busy=1 -> ignored; step progression is unchanged.
